// File: rtl/fan_cfg_sequencer.sv
// fan_cfg_sequencer: configuration front-end of the fan controller.
// Bytes arrive on a slow strobe port and are assembled into the register
// set used by the PID loop: setpoint, Kp, Ki and Kd.
//
// Data path:  pins -> synchroniser -> staging -> shadow -> outputs.
// A config transaction fills the staging copy. The staging copy is moved
// into the shadow set only once the transaction is complete. The shadow
// set reaches the outputs only on a PID tick, so the loop never sees a
// half-written parameter set.
//
// Optional feature: define CFG_CHECKSUM_EN to require a trailing mod-256
// checksum byte (header + payload) on every config transaction.

module fan_cfg_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    input  logic       config_en_i,
    input  logic       pid_tick_i,
    output logic [7:0] setpoint_o,
    output logic [7:0] kp_o,
    output logic [7:0] ki_o,
    output logic [7:0] kd_o,
    output logic       commit_o,
    output logic       cfg_busy_o,
    output logic       cfg_err_o
);

    // state    | meaning
    // ---------+----------------------------------------------------------
    // ST_IDLE  | waiting for a setpoint byte or a config header
    // ST_PAYLD | receiving payload bytes into the staging copy
    // ST_CHECK | waiting for the checksum byte (checksum builds only)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAYLD = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    // Synchroniser chains; index SYNC_STAGES-1 is the oldest (safe) stage.
    logic [SYNC_STAGES-1:0]      vld_sync_q, vld_sync_d;
    logic [SYNC_STAGES-1:0]      en_sync_q, en_sync_d;
    logic [SYNC_STAGES-1:0][7:0] dat_sync_q, dat_sync_d;
    logic                        vld_prev_q, vld_prev_d;

    logic       stb;
    logic       en_s;
    logic [7:0] byte_s;

    state_t          state_q, state_d;
    logic [1:0]      addr_q, addr_d;
    logic [2:0]      rem_q, rem_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [3:0][7:0] staging_q, staging_d;
    logic [3:0][7:0] shadow_q, shadow_d;
    logic            pending_q, pending_d;
    logic [3:0][7:0] out_q, out_d;
    logic            commit_q, commit_d;
    logic            err_q, err_d;
`ifdef CFG_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    logic complete;
    logic sp_write;
    logic err_set;
    logic commit_now;

    // Shift the raw pins through the synchroniser and keep the last synced valid.
    always_comb begin
        vld_sync_d = {vld_sync_q[SYNC_STAGES-2:0], data_valid_i};
        en_sync_d  = {en_sync_q[SYNC_STAGES-2:0], config_en_i};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], data_i};
        vld_prev_d = vld_sync_q[SYNC_STAGES-1];
    end

    // Rising edge of the synced valid; data and enable come from the same stage.
    always_comb begin
        stb    = vld_sync_q[SYNC_STAGES-1] & ~vld_prev_q;
        en_s   = en_sync_q[SYNC_STAGES-1];
        byte_s = dat_sync_q[SYNC_STAGES-1];
    end

    // Transaction FSM: next state, staging/shadow updates, timeout handling.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        tmo_d     = tmo_q;
        staging_d = staging_q;
        shadow_d  = shadow_q;
        complete  = 1'b0;
        sp_write  = 1'b0;
        err_set   = 1'b0;
`ifdef CFG_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (stb) begin
                    if (!en_s) begin
                        shadow_d[0] = byte_s;
                        sp_write    = 1'b1;
                    end else if (byte_s[7:4] == 4'hA) begin
                        addr_d    = byte_s[1:0];
                        rem_d     = {1'b0, byte_s[3:2]} + 3'd1;
                        staging_d = shadow_q;
`ifdef CFG_CHECKSUM_EN
                        csum_d    = byte_s;
`endif
                        state_d   = ST_PAYLD;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end

            ST_PAYLD: begin
                if (stb) begin
                    tmo_d = '0;
                    if (en_s) begin
                        staging_d[addr_q] = byte_s;
                        addr_d            = addr_q + 2'd1;
                        rem_d             = rem_q - 3'd1;
`ifdef CFG_CHECKSUM_EN
                        csum_d            = csum_q + byte_s;
`endif
                        if (rem_q == 3'd1) begin
`ifdef CFG_CHECKSUM_EN
                            state_d  = ST_CHECK;
`else
                            complete = 1'b1;
                            state_d  = ST_IDLE;
`endif
                        end
                    end else begin
                        err_set = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

`ifdef CFG_CHECKSUM_EN
            ST_CHECK: begin
                if (stb) begin
                    tmo_d   = '0;
                    state_d = ST_IDLE;
                    if (en_s && (byte_s == csum_q)) begin
                        complete = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end
        endcase

        // staging_d already holds the final payload byte when completing from ST_PAYLD.
        if (complete) begin
            shadow_d = staging_d;
        end
    end

    // Commit the shadow set on a tick; new data landing on the same edge stays pending.
    always_comb begin
        commit_now = pid_tick_i & pending_q;
        out_d      = out_q;
        commit_d   = commit_now;
        pending_d  = pending_q;
        err_d      = err_q;

        if (commit_now) begin
            out_d     = shadow_q;
            pending_d = 1'b0;
            err_d     = 1'b0;
        end
        if (complete || sp_write) begin
            pending_d = 1'b1;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    // State and data registers; reset discards any partial transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sync_q <= '0;
            en_sync_q  <= '0;
            dat_sync_q <= '0;
            vld_prev_q <= 1'b0;
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            tmo_q      <= '0;
            staging_q  <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            out_q      <= '0;
            commit_q   <= 1'b0;
            err_q      <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            vld_sync_q <= vld_sync_d;
            en_sync_q  <= en_sync_d;
            dat_sync_q <= dat_sync_d;
            vld_prev_q <= vld_prev_d;
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            tmo_q      <= tmo_d;
            staging_q  <= staging_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            out_q      <= out_d;
            commit_q   <= commit_d;
            err_q      <= err_d;
`ifdef CFG_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign setpoint_o = out_q[0];
    assign kp_o       = out_q[1];
    assign ki_o       = out_q[2];
    assign kd_o       = out_q[3];
    assign commit_o   = commit_q;
    assign cfg_busy_o = (state_q != ST_IDLE);
    assign cfg_err_o  = err_q;

endmodule

// File: tb/tb_fan_cfg_sequencer.sv
// Directed bench for fan_cfg_sequencer. Expected register sets are queued
// when a committing tick is issued and checked when commit_o fires.
// Build with +define+CFG_CHECKSUM_EN to exercise the checksum variant.

module tb_fan_cfg_sequencer;

    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_i;
    logic       data_valid_i;
    logic       config_en_i;
    logic       pid_tick_i;
    logic [7:0] setpoint_o, kp_o, ki_o, kd_o;
    logic       commit_o, cfg_busy_o, cfg_err_o;

    typedef struct packed {
        logic [7:0] sp;
        logic [7:0] kp;
        logic [7:0] ki;
        logic [7:0] kd;
    } regs_t;

    regs_t exp_q[$];
    regs_t mon_e;
    int    pass_cnt    = 0;
    int    total_cnt   = 0;
    int    commit_cnt  = 0;
    int    exp_commits = 0;

    fan_cfg_sequencer #(
        .SYNC_STAGES(2),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .config_en_i  (config_en_i),
        .pid_tick_i   (pid_tick_i),
        .setpoint_o   (setpoint_o),
        .kp_o         (kp_o),
        .ki_o         (ki_o),
        .kd_o         (kd_o),
        .commit_o     (commit_o),
        .cfg_busy_o   (cfg_busy_o),
        .cfg_err_o    (cfg_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Scoreboard consumer: every commit pulse cycle must match a queued expectation.
    always @(negedge clk) begin
        if (!rst && commit_o) begin
            commit_cnt++;
            check("commit_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("commit_sp", {24'd0, setpoint_o}, {24'd0, mon_e.sp});
                check("commit_kp", {24'd0, kp_o}, {24'd0, mon_e.kp});
                check("commit_ki", {24'd0, ki_o}, {24'd0, mon_e.ki});
                check("commit_kd", {24'd0, kd_o}, {24'd0, mon_e.kd});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic en);
        data_i       = b;
        config_en_i  = en;
        data_valid_i = 1'b1;
        cyc(3);
        data_valid_i = 1'b0;
        cyc(3);
    endtask

    task automatic tick();
        pid_tick_i = 1'b1;
        cyc(1);
        pid_tick_i = 1'b0;
    endtask

    task automatic expect_commit(input logic [7:0] sp, input logic [7:0] kp,
                                 input logic [7:0] ki, input logic [7:0] kd);
        exp_q.push_back({sp, kp, ki, kd});
        exp_commits++;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1);
        check({tag, "_drain"}, exp_q.size(), 32'd0);
        cyc(3);
        check({tag, "_commit_count"}, commit_cnt, exp_commits);
    endtask

    task automatic no_commit_tick(input string tag);
        tick();
        cyc(5);
        check({tag, "_no_commit"}, commit_cnt, exp_commits);
    endtask

    task automatic check_outs(input string tag, input logic [7:0] sp, input logic [7:0] kp,
                              input logic [7:0] ki, input logic [7:0] kd);
        check({tag, "_outs"}, {setpoint_o, kp_o, ki_o, kd_o}, {sp, kp, ki, kd});
    endtask

    initial begin
        rst          = 1'b1;
        data_i       = 8'h00;
        data_valid_i = 1'b0;
        config_en_i  = 1'b0;
        pid_tick_i   = 1'b0;
        cyc(4);

        // Reset state
        check_outs("reset", 8'h00, 8'h00, 8'h00, 8'h00);
        check("reset_commit", {31'd0, commit_o}, 32'd0);
        check("reset_busy", {31'd0, cfg_busy_o}, 32'd0);
        check("reset_err", {31'd0, cfg_err_o}, 32'd0);
        rst = 1'b0;
        cyc(3);
        no_commit_tick("idle_tick");
        check_outs("after_idle_tick", 8'h00, 8'h00, 8'h00, 8'h00);

        // Setpoint-only write
        send_byte(8'h32, 1'b0);
        check("sp_write_busy", {31'd0, cfg_busy_o}, 32'd0);
        cyc(10);
        expect_commit(8'h32, 8'h00, 8'h00, 8'h00);
        tick();
        drain("sp_write");

        // Full four-register transaction
        send_byte(8'hAC, 1'b1);
        check("full_busy", {31'd0, cfg_busy_o}, 32'd1);
        send_byte(8'h40, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
`ifdef CFG_CHECKSUM_EN
        check("full_busy_chk", {31'd0, cfg_busy_o}, 32'd1);
        send_byte(8'h52, 1'b1);
`endif
        check("full_idle", {31'd0, cfg_busy_o}, 32'd0);
        check("full_err", {31'd0, cfg_err_o}, 32'd0);
        check_outs("full_before_tick", 8'h32, 8'h00, 8'h00, 8'h00);
        expect_commit(8'h40, 8'h11, 8'h22, 8'h33);
        tick();
        drain("full");

        // Address wrap KD -> SP
        send_byte(8'hA7, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h06, 1'b1);
`ifdef CFG_CHECKSUM_EN
        send_byte(8'hB2, 1'b1);
`endif
        expect_commit(8'h06, 8'h11, 8'h22, 8'h05);
        tick();
        drain("wrap");

        // Timeout mid-transaction
        send_byte(8'hA4, 1'b1);
        send_byte(8'h77, 1'b1);
        check("tmo_busy_before", {31'd0, cfg_busy_o}, 32'd1);
        cyc(TMO + 20);
        check("tmo_err", {31'd0, cfg_err_o}, 32'd1);
        check("tmo_busy", {31'd0, cfg_busy_o}, 32'd0);
        no_commit_tick("tmo");
        check_outs("tmo_outs", 8'h06, 8'h11, 8'h22, 8'h05);
        check("tmo_err_held", {31'd0, cfg_err_o}, 32'd1);

        // A successful commit clears the error flag
        send_byte(8'h09, 1'b0);
        expect_commit(8'h09, 8'h11, 8'h22, 8'h05);
        tick();
        drain("err_clear");
        check("err_cleared", {31'd0, cfg_err_o}, 32'd0);

        // Bad header
        send_byte(8'h64, 1'b1);
        check("bad_hdr_err", {31'd0, cfg_err_o}, 32'd1);
        check("bad_hdr_busy", {31'd0, cfg_busy_o}, 32'd0);
        no_commit_tick("bad_hdr");

        // Abort by a non-config byte: byte dropped, nothing pending
        send_byte(8'hA4, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h99, 1'b0);
        check("abort_busy", {31'd0, cfg_busy_o}, 32'd0);
        check("abort_err", {31'd0, cfg_err_o}, 32'd1);
        no_commit_tick("abort");
        check_outs("abort_outs", 8'h09, 8'h11, 8'h22, 8'h05);

        // Tick between payload bytes commits only the earlier setpoint
        send_byte(8'h20, 1'b0);
        send_byte(8'hA4, 1'b1);
        send_byte(8'h55, 1'b1);
        expect_commit(8'h20, 8'h11, 8'h22, 8'h05);
        tick();
        drain("mid_tick");
        check("mid_tick_busy", {31'd0, cfg_busy_o}, 32'd1);
        send_byte(8'h66, 1'b1);
`ifdef CFG_CHECKSUM_EN
        send_byte(8'h5F, 1'b1);
`endif
        check("mid_done_busy", {31'd0, cfg_busy_o}, 32'd0);
        check_outs("mid_before_tick", 8'h20, 8'h11, 8'h22, 8'h05);
        expect_commit(8'h55, 8'h66, 8'h22, 8'h05);
        tick();
        drain("mid_payload");

`ifdef CFG_CHECKSUM_EN
        // Wrong checksum discards the transaction
        send_byte(8'hA4, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        check("bad_csum_err", {31'd0, cfg_err_o}, 32'd1);
        check("bad_csum_busy", {31'd0, cfg_busy_o}, 32'd0);
        no_commit_tick("bad_csum");
        check_outs("bad_csum_outs", 8'h55, 8'h66, 8'h22, 8'h05);
`endif

        // Reset mid-transaction: no partial commit afterwards
        send_byte(8'hA4, 1'b1);
        send_byte(8'h33, 1'b1);
        rst = 1'b1;
        cyc(2);
        check_outs("midrst", 8'h00, 8'h00, 8'h00, 8'h00);
        check("midrst_busy", {31'd0, cfg_busy_o}, 32'd0);
        check("midrst_err", {31'd0, cfg_err_o}, 32'd0);
        rst = 1'b0;
        cyc(2);
        send_byte(8'h44, 1'b1);
        no_commit_tick("midrst");
        check_outs("midrst_after", 8'h00, 8'h00, 8'h00, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
